// File: rtl/fsm_par_demux.sv
// Stream demux behind the parallel FSM checker: drops errored streams up to the next header,
// buffers accepted words in a FIFO and steers them to two lanes by LSB. Option: FSM_PAR_DEMUX_DROPCNT_EN.
module fsm_par_demux #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned AW        = $clog2(FIFO_DEPTH),
    localparam int unsigned CW        = AW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] bus_data_in,
    input  logic              valid_in,
    input  logic              error_in,
    output logic              ready_out,
    output logic [DATA_W-1:0] data_out_0,
    output logic [DATA_W-1:0] data_out_1,
    output logic              valid_0,
    output logic              valid_1,
    input  logic              ready_0,
    input  logic              ready_1,
    output logic [CW-1:0]     fifo_count,
    output logic              overflow,
    output logic [1:0]        state
`ifdef FSM_PAR_DEMUX_DROPCNT_EN
    ,
    output logic [7:0]        drop_cnt
`endif
);

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StPass    = 2'b01,
        StDiscard = 2'b10,
        StBad     = 2'b11
    } state_e;

    state_e            r_state;
    state_e            w_state_d;
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [DATA_W-1:0] r_out_q;
    logic              r_out_vld;
    logic              r_overflow;

    logic w_hdr;
    logic w_full;
    logic w_accept;
    logic w_push;
    logic w_ovf;
    logic w_drop;
    logic w_lane_rdy;
    logic w_slot_free;
    logic w_pop;

    always_comb begin
        w_hdr     = (bus_data_in[DATA_W-1 -: 4] == 4'hF);
        w_accept  = 1'b0;
        w_state_d = r_state;
        if (r_state == StBad) begin
            w_state_d = StIdle;
        end else if (valid_in) begin
            unique case (r_state)
                StIdle: begin
                    if (error_in) begin
                        w_state_d = StDiscard;
                    end else if (w_hdr) begin
                        w_accept  = 1'b1;
                        w_state_d = StPass;
                    end
                end
                StPass: begin
                    if (error_in) begin
                        w_state_d = StDiscard;
                    end else begin
                        w_accept = 1'b1;
                    end
                end
                StDiscard: begin
                    if (w_hdr && !error_in) begin
                        w_accept  = 1'b1;
                        w_state_d = StPass;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    // Fullness comes from the registered count, so a same-cycle pop never rescues a push.
    assign w_full      = (r_count == CW'(FIFO_DEPTH));
    assign w_push      = w_accept & ~w_full;
    assign w_ovf       = w_accept & w_full;
    assign w_drop      = (valid_in & ~w_accept) | w_ovf;
    assign w_lane_rdy  = r_out_q[0] ? ready_1 : ready_0;
    assign w_slot_free = ~r_out_vld | w_lane_rdy;
    assign w_pop       = w_slot_free & (r_count != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StIdle;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (w_ovf) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus_data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_out_q   <= '0;
            r_out_vld <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_out_q  <= r_mem[r_rd_ptr];
            end
            if (w_slot_free) begin
                r_out_vld <= w_pop;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

`ifdef FSM_PAR_DEMUX_DROPCNT_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`else
    logic w_unused_drop;
    assign w_unused_drop = w_drop;
`endif

    assign ready_out  = ~w_full;
    assign data_out_0 = r_out_q;
    assign data_out_1 = r_out_q;
    assign valid_0    = r_out_vld & ~r_out_q[0];
    assign valid_1    = r_out_vld & r_out_q[0];
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign state      = r_state;

endmodule
